sonar_mmio: RTL
===============

SONAR_MMIO -- requirements
Module: sonar_mmio

Interface
REQ-001 Parameter BASE_ADDR, default 12'hF00: word address of register 0; the block decodes BASE_ADDR..BASE_ADDR+3.
REQ-002 Parameter TRIG_CYCLES, default 1000: trigger pulse width in clock cycles, range 1..2^16-1.
REQ-003 Parameter TIMEOUT_CYCLES, default 3_000_000: maximum cycles from trigger fall to echo fall, range 2..2^24-1.
REQ-004 Port clock, input, 1: the single system clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port wren, input, 1: data-bus write enable from the processor.
REQ-007 Port address_dmem, input, 12: data-bus word address.
REQ-008 Port data, input, 32: data-bus write data.
REQ-009 Port q_sonar, output, 32: registered read data.
REQ-010 Port sel, output, 1: registered; high when the previous cycle's address hit this block, for the read-data mux.
REQ-011 Port echo, input, 1: asynchronous echo from the ultrasonic sensor.
REQ-012 Port trig, output, 1: registered trigger to the sensor.

Function
REQ-013 The echo input SHALL pass through a 2-flop synchronizer; all echo logic uses the synchronized value and its previous sample (rise = 0->1, fall = 1->0).
REQ-014 Register map (offset = address_dmem - BASE_ADDR): 0 CTRL, 1 STATUS {29'b0, timeout, valid, busy}, 2 RESULT (24-bit echo width, zero-extended), 3 COUNT (32-bit completed-measurement count).
REQ-015 Reads SHALL have 1-cycle latency: q_sonar and sel in cycle N+1 reflect the address in cycle N; q_sonar = 0 when the address is not in range.
REQ-016 A write to CTRL with data[0]=1 while the state is IDLE SHALL start a measurement; a write while busy, a write with data[0]=0, and writes to offsets 1-3 SHALL be ignored.
REQ-017 FSM states: IDLE, TRIG, WAIT_RISE, MEASURE; busy = (state != IDLE).
REQ-018 IDLE -> TRIG on start: clears valid and timeout, asserts trig on the next edge.
REQ-019 TRIG: holds trig high for exactly TRIG_CYCLES cycles, then -> WAIT_RISE with trig low and the timeout counter cleared.
REQ-020 WAIT_RISE: on an echo rise -> MEASURE with the width counter = 0; an echo already high on entry SHALL NOT count as a rise.
REQ-021 MEASURE: the width counter increments every cycle; on an echo fall, RESULT <= counter, valid <= 1, COUNT += 1, -> IDLE.
REQ-022 The timeout counter SHALL run in WAIT_RISE and MEASURE; when it reaches TIMEOUT_CYCLES: timeout <= 1, valid stays 0, RESULT <= 24'hFFFFFF, COUNT unchanged, -> IDLE.
REQ-023 If an echo fall and the timeout occur in the same cycle, the fall wins (valid result).
REQ-024 COUNT SHALL wrap from 32'hFFFFFFFF to 0.
REQ-025 A read of STATUS in the same cycle as a completing edge SHALL return the pre-update value; the new value is visible on the following read.

Reset
REQ-026 On reset: state = IDLE, trig = 0, q_sonar = 0, sel = 0, busy/valid/timeout = 0, RESULT = 0, COUNT = 0, synchronizer flops = 0, all counters = 0.
REQ-027 Reset asserted mid-measurement SHALL abort within one edge, with trig low on that edge and no update to COUNT.

Verification (TRIG_CYCLES=4, TIMEOUT_CYCLES=100, BASE_ADDR=12'hF00)
REQ-028 Write 1 to 0xF00, echo high 20 cycles after trig falls and held 37 cycles -> trig high exactly 4 cycles; STATUS reads 3'b010; RESULT = 37 +/- 1 fixed sync offset; COUNT = 1.
REQ-029 Start, echo never rises -> 100 cycles after trig falls, STATUS = 3'b100, RESULT = 0xFFFFFF, COUNT = 0.
REQ-030 Echo held high through the trigger -> no measurement starts; ends in timeout (STATUS = 3'b100).
REQ-031 Second CTRL write during MEASURE -> ignored; one result, COUNT increments by 1 only.
REQ-032 Reads of 0xEFF and 0xF04 -> q_sonar = 0, sel = 0; read of 0xF01 -> sel = 1 one cycle later.
REQ-033 Reset pulse in MEASURE -> next cycle all registers 0, trig = 0; a new start afterwards measures normally.

Source files
------------

// File: rtl/sonar_mmio.sv
// Memory-mapped ultrasonic range controller: fires a trigger pulse, times the
// echo high width and exposes CTRL/STATUS/RESULT/COUNT on the data bus.
//
// state       | meaning
// ------------+--------------------------------------------------------
// S_IDLE      | waiting for a CTRL start write
// S_TRIG      | trig held high, trigger down-counter running
// S_WAIT_RISE | trig low, waiting for echo rise, timeout counter running
// S_MEASURE   | echo high, width and timeout counters running
module sonar_mmio #(
  parameter logic [11:0] BASE_ADDR      = 12'hF00,
  parameter int unsigned TRIG_CYCLES    = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 3_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wren,
  input  logic [11:0] address_dmem,
  input  logic [31:0] data,
  output logic [31:0] q_sonar,
  output logic        sel,
  input  logic        echo,
  output logic        trig
);

  typedef enum logic [1:0] {S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE} state_t;

  localparam logic [15:0] TRIG_LOAD  = 16'(TRIG_CYCLES - 1);
  localparam logic [23:0] TIMEOUT_TC = 24'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic        trig_q, trig_d;
  logic        echo_s1_q, echo_s1_d;
  logic        echo_s2_q, echo_s2_d;
  logic        echo_prev_q, echo_prev_d;
  logic [15:0] trig_cnt_q, trig_cnt_d;
  logic [23:0] timeout_cnt_q, timeout_cnt_d;
  logic [23:0] width_q, width_d;
  logic [23:0] result_q, result_d;
  logic [31:0] count_q, count_d;
  logic        valid_q, valid_d;
  logic        timeout_q, timeout_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        sel_q, sel_d;

  logic [11:0] offset;
  logic        hit;
  logic        start;
  logic        busy;
  logic        echo_rise;
  logic        echo_fall;
  logic        data_unused;

  assign data_unused = ^data[31:1];

  always_comb begin
    state_d       = state_q;
    trig_d        = trig_q;
    echo_s1_d     = echo;
    echo_s2_d     = echo_s1_q;
    echo_prev_d   = echo_s2_q;
    trig_cnt_d    = trig_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    width_d       = width_q;
    result_d      = result_q;
    count_d       = count_q;
    valid_d       = valid_q;
    timeout_d     = timeout_q;
    rd_data_d     = '0;
    sel_d         = 1'b0;

    offset    = address_dmem - BASE_ADDR;
    hit       = (offset < 12'd4);
    busy      = (state_q != S_IDLE);
    start     = wren && hit && (offset[1:0] == 2'd0) && data[0];
    echo_rise = echo_s2_q & ~echo_prev_q;
    echo_fall = ~echo_s2_q & echo_prev_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_TRIG;
          trig_d     = 1'b1;
          trig_cnt_d = TRIG_LOAD;
          valid_d    = 1'b0;
          timeout_d  = 1'b0;
        end
      end
      S_TRIG: begin
        if (trig_cnt_q == 16'd0) begin
          state_d       = S_WAIT_RISE;
          trig_d        = 1'b0;
          timeout_cnt_d = '0;
        end else begin
          trig_cnt_d = trig_cnt_q - 16'd1;
        end
      end
      S_WAIT_RISE: begin
        timeout_cnt_d = timeout_cnt_q + 24'd1;
        if (timeout_cnt_d == TIMEOUT_TC) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
          result_d  = 24'hFFFFFF;
        end else if (echo_rise) begin
          state_d = S_MEASURE;
          width_d = '0;
        end
      end
      S_MEASURE: begin
        timeout_cnt_d = timeout_cnt_q + 24'd1;
        width_d       = width_q + 24'd1;
        // A fall on the timeout cycle still yields a valid result.
        if (echo_fall) begin
          state_d  = S_IDLE;
          result_d = width_q;
          valid_d  = 1'b1;
          count_d  = count_q + 32'd1;
        end else if (timeout_cnt_d == TIMEOUT_TC) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
          result_d  = 24'hFFFFFF;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (hit) begin
      sel_d = 1'b1;
      case (offset[1:0])
        2'd1:    rd_data_d = {29'b0, timeout_q, valid_q, busy};
        2'd2:    rd_data_d = {8'b0, result_q};
        2'd3:    rd_data_d = count_q;
        default: rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      trig_q        <= 1'b0;
      echo_s1_q     <= 1'b0;
      echo_s2_q     <= 1'b0;
      echo_prev_q   <= 1'b0;
      trig_cnt_q    <= '0;
      timeout_cnt_q <= '0;
      width_q       <= '0;
      result_q      <= '0;
      count_q       <= '0;
      valid_q       <= 1'b0;
      timeout_q     <= 1'b0;
      rd_data_q     <= '0;
      sel_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      trig_q        <= trig_d;
      echo_s1_q     <= echo_s1_d;
      echo_s2_q     <= echo_s2_d;
      echo_prev_q   <= echo_prev_d;
      trig_cnt_q    <= trig_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      width_q       <= width_d;
      result_q      <= result_d;
      count_q       <= count_d;
      valid_q       <= valid_d;
      timeout_q     <= timeout_d;
      rd_data_q     <= rd_data_d;
      sel_q         <= sel_d;
    end
  end

  assign q_sonar = rd_data_q;
  assign sel     = sel_q;
  assign trig    = trig_q;

endmodule
